// File: rtl/ps_sync_ctrl.sv
// rtl/ps_sync_ctrl.sv - program-state synchronizer: stall fetch, flush front end / TLB, then commit
module ps_sync_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [12:0]      i_ps,
  output logic [12:0]      o_ps_cur,
  output logic             o_stall,
  output logic             o_flush_req,
  input  logic             i_flush_ack,
  output logic             o_tlb_flush,
  output logic [8:0]       o_tlb_flush_asid,
  input  logic             i_tlb_done,
  output logic [CNT_W-1:0] o_sync_cnt,
  input  logic [31:0]      i_log_fd
);

  localparam logic [12:0] PS_RESET = 13'h1800;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_TLB,
    S_COMMIT
  } state_e;

  state_e           state_q, state_d;
  logic [12:0]      ps_cur_q, ps_cur_d;
  logic [12:0]      ps_pend_q, ps_pend_d;
  logic             xlat_chg_q, xlat_chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stall_q, stall_d;
  logic             flush_req_q, flush_req_d;
  logic             tlb_flush_q, tlb_flush_d;
  logic [8:0]       tlb_asid_q, tlb_asid_d;

  always_comb begin
    state_d    = state_q;
    ps_cur_d   = ps_cur_q;
    ps_pend_d  = ps_pend_q;
    xlat_chg_d = xlat_chg_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_ps != ps_cur_q) begin
          ps_pend_d  = i_ps;
          // mode or asid moved: the old translations are stale
          xlat_chg_d = (i_ps[9:0] != ps_cur_q[9:0]);
          state_d    = S_REQ;
        end
      end
      S_REQ: begin
        if (i_flush_ack) state_d = xlat_chg_q ? S_TLB : S_COMMIT;
      end
      S_TLB: begin
        if (i_tlb_done) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        ps_cur_d = ps_pend_q;
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // outputs are registered copies decoded from the next state
    stall_d     = (state_d != S_IDLE);
    flush_req_d = (state_d == S_REQ);
    tlb_flush_d = (state_d == S_TLB);
    tlb_asid_d  = (state_d == S_TLB) ? ps_cur_q[8:0] : 9'd0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      ps_cur_q    <= PS_RESET;
      ps_pend_q   <= PS_RESET;
      xlat_chg_q  <= 1'b0;
      cnt_q       <= '0;
      stall_q     <= 1'b0;
      flush_req_q <= 1'b0;
      tlb_flush_q <= 1'b0;
      tlb_asid_q  <= 9'd0;
    end else begin
      state_q     <= state_d;
      ps_cur_q    <= ps_cur_d;
      ps_pend_q   <= ps_pend_d;
      xlat_chg_q  <= xlat_chg_d;
      cnt_q       <= cnt_d;
      stall_q     <= stall_d;
      flush_req_q <= flush_req_d;
      tlb_flush_q <= tlb_flush_d;
      tlb_asid_q  <= tlb_asid_d;
    end
  end

  assign o_ps_cur         = ps_cur_q;
  assign o_stall          = stall_q;
  assign o_flush_req      = flush_req_q;
  assign o_tlb_flush      = tlb_flush_q;
  assign o_tlb_flush_asid = tlb_asid_q;
  assign o_sync_cnt       = cnt_q;

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (i_rst_n && (state_d != state_q))
      $display("%0t ps_sync_ctrl[%0d] %s -> %s cur=%h pend=%h", $time, i_log_fd,
               state_q.name(), state_d.name(), ps_cur_q, ps_pend_d);
  end
`endif

endmodule

// File: tb/tb_ps_sync_ctrl.sv
// tb/tb_ps_sync_ctrl.sv - randomized and directed self-checking bench for ps_sync_ctrl
module tb_ps_sync_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [12:0]      i_ps;
  logic             ack, done;
  logic [12:0]      ps_cur;
  logic             stall, flush_req, tlb_flush;
  logic [8:0]       tlb_asid;
  logic [CNT_W-1:0] sync_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ps_sync_ctrl #(.CNT_W(CNT_W)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_ps             (i_ps),
    .o_ps_cur         (ps_cur),
    .o_stall          (stall),
    .o_flush_req      (flush_req),
    .i_flush_ack      (ack),
    .o_tlb_flush      (tlb_flush),
    .o_tlb_flush_asid (tlb_asid),
    .i_tlb_done       (done),
    .o_sync_cnt       (sync_cnt),
    .i_log_fd         (32'h1)
  );

  // Transaction-level view: a sync is busy until its flush is acked, then (if
  // translation changed) until the TLB is done, then spends one cycle committing.
  typedef struct packed {
    logic [12:0]      cur;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             ack_seen;
    logic             tlb_seen;
    logic             need_tlb;
    logic [12:0]      pend;
  } model_t;

  localparam model_t M_RST = '{cur: 13'h1800, cnt: '0, busy: 1'b0, ack_seen: 1'b0,
                               tlb_seen: 1'b0, need_tlb: 1'b0, pend: 13'h0};

  model_t m;

  function automatic model_t model_next(model_t s, logic [12:0] ps, logic a, logic d);
    model_t n = s;
    if (!s.busy) begin
      if (ps != s.cur) begin
        n.busy     = 1'b1;
        n.pend     = ps;
        n.need_tlb = (ps[9:0] != s.cur[9:0]);
        n.ack_seen = 1'b0;
        n.tlb_seen = 1'b0;
      end
    end else if (!s.ack_seen) begin
      n.ack_seen = a;
    end else if (s.need_tlb && !s.tlb_seen) begin
      n.tlb_seen = d;
    end else begin
      n.cur  = s.pend;
      n.cnt  = s.cnt + 1'b1;
      n.busy = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RST;
    else        m <= model_next(m, i_ps, ack, done);
  end

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  logic exp_tlb;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_tlb = m.busy && m.ack_seen && m.need_tlb && !m.tlb_seen;
      chk("m_stall",     32'(stall),     32'(m.busy));
      chk("m_flush_req", 32'(flush_req), 32'(m.busy && !m.ack_seen));
      chk("m_tlb_flush", 32'(tlb_flush), 32'(exp_tlb));
      chk("m_tlb_asid",  32'(tlb_asid),  32'(exp_tlb ? m.cur[8:0] : 9'd0));
      chk("m_ps_cur",    32'(ps_cur),    32'(m.cur));
      chk("m_sync_cnt",  32'(sync_cnt),  32'(m.cnt));
    end
  end

  task automatic quick_sync(input logic [12:0] v);
    int n;
    i_ps = v;
    @(negedge clk);
    ack = 1'b1;
    done = 1'b1;
    n = 0;
    while (stall && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("quick_sync_timeout", 32'(stall), 32'h0);
    ack = 1'b0;
    done = 1'b0;
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    i_ps  = 13'h1800;
    ack   = 1'b0;
    done  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // reset state with i_ps equal to the committed value
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_flush", 32'(flush_req), 32'h0);
    chk("rst_tlb", 32'(tlb_flush), 32'h0);
    chk("rst_cnt", 32'(sync_cnt), 32'h0);
    chk("rst_ps_cur", 32'(ps_cur), 32'h1800);

    // priv-only change, minimum latency
    i_ps = 13'h0000;
    @(negedge clk);
    chk("t2_flush_n1", 32'(flush_req), 32'h1);
    chk("t2_stall_n1", 32'(stall), 32'h1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t2_notlb_n2", 32'(tlb_flush), 32'h0);
    chk("t2_stall_n2", 32'(stall), 32'h1);
    @(negedge clk);
    chk("t2_ps_cur_n3", 32'(ps_cur), 32'h0000);
    chk("t2_cnt_n3", 32'(sync_cnt), 32'h1);
    chk("t2_stall_n3", 32'(stall), 32'h0);

    // asid + mode change, delayed ack and done
    i_ps = 13'h0205;
    @(negedge clk);
    repeat (3) begin
      chk("t3_flush_hold", 32'(flush_req), 32'h1);
      @(negedge clk);
    end
    chk("t3_flush_hold", 32'(flush_req), 32'h1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t3_tlb_on", 32'(tlb_flush), 32'h1);
    chk("t3_tlb_asid", 32'(tlb_asid), 32'h0);
    chk("t3_flush_off", 32'(flush_req), 32'h0);
    @(negedge clk);
    chk("t3_tlb_hold", 32'(tlb_flush), 32'h1);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("t3_tlb_off", 32'(tlb_flush), 32'h0);
    chk("t3_stall_commit", 32'(stall), 32'h1);
    @(negedge clk);
    chk("t3_ps_cur", 32'(ps_cur), 32'h0205);
    chk("t3_cnt", 32'(sync_cnt), 32'h2);
    chk("t3_stall_off", 32'(stall), 32'h0);

    // i_ps toggles while a sequence waits for ack
    i_ps = 13'h0A05;
    @(negedge clk);
    i_ps = 13'h1234;
    @(negedge clk);
    i_ps = 13'h0206;
    chk("t4_flush", 32'(flush_req), 32'h1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t4_notlb", 32'(tlb_flush), 32'h0);
    @(negedge clk);
    chk("t4_ps_cur1", 32'(ps_cur), 32'h0A05);
    chk("t4_idle_gap", 32'(stall), 32'h0);
    chk("t4_cnt1", 32'(sync_cnt), 32'h3);
    @(negedge clk);
    chk("t4_req2", 32'(flush_req), 32'h1);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t4_tlb2", 32'(tlb_flush), 32'h1);
    chk("t4_asid2", 32'(tlb_asid), 32'h005);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    chk("t4_ps_cur2", 32'(ps_cur), 32'h0206);
    chk("t4_cnt2", 32'(sync_cnt), 32'h4);

    // asynchronous reset while in TLB
    i_ps = 13'h0307;
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t6_in_tlb", 32'(tlb_flush), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_tlb_drop", 32'(tlb_flush), 32'h0);
    chk("t6_stall_drop", 32'(stall), 32'h0);
    chk("t6_ps_cur", 32'(ps_cur), 32'h1800);
    chk("t6_cnt", 32'(sync_cnt), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_restart", 32'(flush_req), 32'h1);
    ack = 1'b1;
    done = 1'b1;
    repeat (3) @(negedge clk);
    ack = 1'b0;
    done = 1'b0;
    chk("t6_ps_cur2", 32'(ps_cur), 32'h0307);
    chk("t6_cnt2", 32'(sync_cnt), 32'h1);

    // counter wrap at 2^CNT_W
    for (int k = 0; k < 15; k++) quick_sync((k % 2 == 0) ? 13'h0000 : 13'h0307);
    chk("t5_wrap_cnt", 32'(sync_cnt), 32'h0);
    chk("t5_wrap_ps", 32'(ps_cur), 32'h0000);
    chk("t5_wrap_stall", 32'(stall), 32'h0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      r = $urandom_range(0, 15);
      case (r)
        0: i_ps[12:11] = 2'($urandom);
        1: i_ps[10] = ~i_ps[10];
        2: i_ps[9] = ~i_ps[9];
        3: i_ps[8:0] = 9'($urandom_range(0, 7));
        4: i_ps = 13'($urandom);
        5: i_ps = m.cur;
        default: ;
      endcase
      ack  = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
